sha256_dhash_sweeper: RTL and testbench

Parametrised Bitcoin double-SHA256 engine with an optional nonce-sweep mode. Accepts an 80-byte block header on a start/done handshake. Hashes either the header as given, or a range of nonces inserted into it, and compares each result against a 256-bit target. Reuses the first-block midstate across nonces and retires RPC compression rounds per clock. Successor to the single-shot double-hash core in the mining datapath.

---
 rtl/sha256_pkg.sv | 63 ++++++
 rtl/sha256_dhash_sweeper_if.sv | 25 ++
 rtl/sha256_compress.sv | 78 +++++++
 rtl/sha256_dhash_sweeper.sv | 143 ++++++++++++++
 tb/tb_sha256_dhash_sweeper.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// SHA-256 round constants, initial hash value, round helper functions and
// the sequencer state encodings shared by the double-hash sweeper.
package sha256_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, CHECK} state_t;
  typedef enum logic [1:0] {C1, C2, C3} comp_sel_t;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] H0 [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] Sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] Sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] byteswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [255:0] byteswap256(input logic [255:0] x);
    logic [255:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[8*i +: 8] = x[255-8*i -: 8];
    return y;
  endfunction

endpackage

// File: rtl/sha256_dhash_sweeper_if.sv
// Request/result bundle of the double-SHA256 sweeper: the requester drives
// start and the operands, the engine returns status and the winning hash.
interface sha256_dhash_sweeper_if;
  logic         start;
  logic         mode;
  logic [639:0] header;
  logic [31:0]  nonce_start;
  logic [31:0]  nonce_count;
  logic [255:0] target;
  logic         busy;
  logic         done;
  logic         found;
  logic [255:0] digest;
  logic [31:0]  nonce_out;

  modport master (
    output start, mode, header, nonce_start, nonce_count, target,
    input  busy, done, found, digest, nonce_out
  );

  modport slave (
    input  start, mode, header, nonce_start, nonce_count, target,
    output busy, done, found, digest, nonce_out
  );
endinterface

// File: rtl/sha256_compress.sv
// One SHA-256 compression: start (load) cycle, 64/RPC round cycles, fin cycle.
// ready flags the last round cycle; cv_out is valid from the cycle after fin.
module sha256_compress
  import sha256_pkg::*;
#(
  parameter int RPC = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         step,
  input  logic         fin,
  input  logic [255:0] cv_in,
  input  logic [511:0] block,
  output logic         ready,
  output logic [255:0] cv_out
);

  logic [7:0][31:0]  st;
  logic [7:0][31:0]  cv;
  logic [15:0][31:0] w;
  logic [5:0]        rnd;
  logic [7:0][31:0]  st_n;
  logic [15:0][31:0] w_n;
  logic [31:0]       t1, t2, nw;
  logic [5:0]        k_idx;

  // RPC rounds chained combinationally; w_n[0] always holds w[t] for the next round
  always_comb begin
    st_n  = st;
    w_n   = w;
    t1    = '0;
    t2    = '0;
    nw    = '0;
    k_idx = '0;
    for (int r = 0; r < RPC; r++) begin
      k_idx = rnd + 6'(r);
      t1 = st_n[7] + Sigma1(st_n[4]) + ch(st_n[4], st_n[5], st_n[6]) + K[k_idx] + w_n[0];
      t2 = Sigma0(st_n[0]) + maj(st_n[0], st_n[1], st_n[2]);
      nw = sigma1(w_n[14]) + w_n[9] + sigma0(w_n[1]) + w_n[0];
      for (int i = 7; i > 0; i--) st_n[i] = st_n[i-1];
      st_n[4] = st_n[4] + t1;
      st_n[0] = t1 + t2;
      for (int i = 0; i < 15; i++) w_n[i] = w_n[i+1];
      w_n[15] = nw;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st  <= '0;
      cv  <= '0;
      w   <= '0;
      rnd <= '0;
    end else if (start) begin
      for (int i = 0; i < 8; i++) begin
        st[i] <= cv_in[255-32*i -: 32];
        cv[i] <= cv_in[255-32*i -: 32];
      end
      for (int i = 0; i < 16; i++) w[i] <= block[511-32*i -: 32];
      rnd <= '0;
    end else if (step) begin
      st  <= st_n;
      w   <= w_n;
      rnd <= rnd + 6'(RPC);
    end else if (fin) begin
      for (int i = 0; i < 8; i++) cv[i] <= cv[i] + st[i];
    end
  end

  assign ready = (rnd == 6'(64 - RPC));

  always_comb begin
    cv_out = '0;
    for (int i = 0; i < 8; i++) cv_out[255-32*i -: 32] = cv[i];
  end

endmodule

// File: rtl/sha256_dhash_sweeper.sv
// Bitcoin double-SHA256 of an 80-byte header, optionally sweeping the nonce field
// with the first-block midstate reused; results update only on the done pulse.
module sha256_dhash_sweeper
  import sha256_pkg::*;
#(
  parameter int RPC = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  sha256_dhash_sweeper_if.slave  bus
);

  localparam logic [255:0] H0_CV = {H0[0], H0[1], H0[2], H0[3], H0[4], H0[5], H0[6], H0[7]};

  state_t       state;
  comp_sel_t    csel;
  logic [639:0] hdr;
  logic         mode_r;
  logic [31:0]  nonce;
  logic [31:0]  remain;
  logic [255:0] target_r;
  logic [255:0] midstate;
  logic         mid_vld;
  logic         empty;
  logic         busy, done, found;
  logic [255:0] digest;
  logic [31:0]  nonce_out;

  logic [639:0] hdr_cur;
  logic [255:0] cmp_cv_in, cmp_cv_out;
  logic [511:0] cmp_block;
  logic         cmp_ready;
  logic         pass;

  // The nonce field carries the current sweep value in its little-endian wire order
  assign hdr_cur = mode_r ? {hdr[639:32], byteswap32(nonce)} : hdr;
  assign pass    = (byteswap256(cmp_cv_out) <= target_r);

  always_comb begin
    cmp_cv_in = H0_CV;
    cmp_block = hdr_cur[639:128];
    case (csel)
      C2: begin
        cmp_cv_in = mid_vld ? midstate : cmp_cv_out;
        cmp_block = {hdr_cur[127:0], 1'b1, 319'd0, 64'd640};
      end
      C3: cmp_block = {cmp_cv_out, 1'b1, 191'd0, 64'd256};
      default: ;
    endcase
  end

  sha256_compress #(.RPC(RPC)) u_compress (
    .clk    (clk),
    .reset  (reset),
    .start  (state == LOAD),
    .step   (state == ROUND),
    .fin    (state == FINAL),
    .cv_in  (cmp_cv_in),
    .block  (cmp_block),
    .ready  (cmp_ready),
    .cv_out (cmp_cv_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      csel      <= C1;
      hdr       <= '0;
      mode_r    <= 1'b0;
      nonce     <= '0;
      remain    <= '0;
      target_r  <= '0;
      midstate  <= '0;
      mid_vld   <= 1'b0;
      empty     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
      digest    <= '0;
      nonce_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          hdr      <= bus.header;
          mode_r   <= bus.mode;
          nonce    <= bus.nonce_start;
          remain   <= bus.nonce_count;
          target_r <= bus.target;
          mid_vld  <= 1'b0;
          csel     <= C1;
          busy     <= 1'b1;
          empty    <= bus.mode && (bus.nonce_count == '0);
          state    <= (bus.mode && (bus.nonce_count == '0)) ? CHECK : LOAD;
        end
        LOAD: begin
          // First C2 after C1 captures the midstate straight off the compressor
          if (csel == C2 && !mid_vld) begin
            midstate <= cmp_cv_out;
            mid_vld  <= 1'b1;
          end
          state <= ROUND;
        end
        ROUND: if (cmp_ready) state <= FINAL;
        FINAL: begin
          case (csel)
            C1:      begin csel <= C2; state <= LOAD; end
            C2:      begin csel <= C3; state <= LOAD; end
            default: state <= CHECK;
          endcase
        end
        CHECK: begin
          if (empty) begin
            found <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else if (!mode_r || pass || remain == 32'd1) begin
            found     <= pass;
            digest    <= cmp_cv_out;
            nonce_out <= byteswap32(hdr_cur[31:0]);
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end else begin
            nonce  <= nonce + 32'd1;
            remain <= remain - 32'd1;
            csel   <= C2;
            state  <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.found     = found;
  assign bus.digest    = digest;
  assign bus.nonce_out = nonce_out;

endmodule

// File: tb/tb_sha256_dhash_sweeper.sv
// Directed bench for the double-SHA256 sweeper at RPC=1 and RPC=4, scoreboarded
// on done-cycle latency, found flag, nonce and digest.
module tb_sha256_dhash_sweeper;

  typedef struct packed {
    logic [15:0]  cyc;
    logic         found;
    logic         chk_dig;
    logic [31:0]  nonce;
    logic [255:0] dig;
  } exp_t;

  localparam logic [639:0] GEN_HDR = {32'h01000000, 256'h0,
    256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
    32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};
  localparam logic [255:0] GEN_DIG = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
  localparam logic [255:0] GEN_TGT = {64'h00000000FFFF0000, 192'h0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         sel, start_v, mode_v;
  logic [639:0] hdr_v;
  logic [31:0]  ns_v, nc_v;
  logic [255:0] tgt_v;

  sha256_dhash_sweeper_if bus1 ();
  sha256_dhash_sweeper_if bus4 ();

  assign bus1.start = start_v & ~sel;
  assign bus4.start = start_v & sel;
  assign bus1.mode = mode_v;         assign bus4.mode = mode_v;
  assign bus1.header = hdr_v;        assign bus4.header = hdr_v;
  assign bus1.nonce_start = ns_v;    assign bus4.nonce_start = ns_v;
  assign bus1.nonce_count = nc_v;    assign bus4.nonce_count = nc_v;
  assign bus1.target = tgt_v;        assign bus4.target = tgt_v;

  sha256_dhash_sweeper #(.RPC(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  sha256_dhash_sweeper #(.RPC(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  logic         busy_m, done_m, found_m;
  logic [255:0] dig_m;
  logic [31:0]  no_m;
  assign busy_m  = sel ? bus4.busy      : bus1.busy;
  assign done_m  = sel ? bus4.done      : bus1.done;
  assign found_m = sel ? bus4.found     : bus1.found;
  assign dig_m   = sel ? bus4.digest    : bus1.digest;
  assign no_m    = sel ? bus4.nonce_out : bus1.nonce_out;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk_exp(input int cyc, input logic f, input logic cd,
                                  input logic [31:0] n, input logic [255:0] d);
    exp_t e;
    e.cyc = 16'(cyc); e.found = f; e.chk_dig = cd; e.nonce = n; e.dig = d;
    return e;
  endfunction

  // Launch one request, optionally re-pulse start mid-flight, then score the result
  task automatic run_op(input string tag, input logic m, input logic [639:0] h,
                        input logic [31:0] ns, input logic [31:0] nc, input logic [255:0] tg,
                        input exp_t e, input int restart_at);
    exp_t got;
    int   cyc;
    sb.push_back(e);
    @(negedge clk);
    mode_v = m; hdr_v = h; ns_v = ns; nc_v = nc; tgt_v = tg; start_v = 1'b1;
    @(posedge clk); #1;
    start_v = 1'b0;
    cyc = 1;
    check({tag, " busy@1"}, 256'(busy_m), 256'(1));
    while (!done_m && cyc < 1000) begin
      if (cyc == restart_at) begin
        start_v = 1'b1; hdr_v = ~h; mode_v = ~m; tgt_v = '0;
      end else begin
        start_v = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start_v = 1'b0;
    got = sb.pop_front();
    check({tag, " done"},  256'(done_m),  256'(1));
    check({tag, " cycle"}, 256'(cyc),     256'(got.cyc));
    check({tag, " busy@done"}, 256'(busy_m), 256'(0));
    check({tag, " found"}, 256'(found_m), 256'(got.found));
    check({tag, " nonce"}, 256'(no_m),    256'(got.nonce));
    if (got.chk_dig) check({tag, " digest"}, dig_m, got.dig);
  endtask

  initial begin
    sel = 1'b0; start_v = 1'b0; mode_v = 1'b0; hdr_v = '0;
    ns_v = '0; nc_v = '0; tgt_v = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("rst busy1",  256'(bus1.busy),  256'(0));
    check("rst done1",  256'(bus1.done),  256'(0));
    check("rst found1", 256'(bus1.found), 256'(0));
    check("rst dig1",   bus1.digest,      256'(0));
    check("rst nonce1", 256'(bus1.nonce_out), 256'(0));
    check("rst busy4",  256'(bus4.busy),  256'(0));
    check("rst dig4",   bus4.digest,      256'(0));

    run_op("m0 rpc1", 1'b0, GEN_HDR, 32'h0, 32'h0, GEN_TGT,
           mk_exp(200, 1'b1, 1'b1, 32'h7c2bac1d, GEN_DIG), 50);

    @(negedge clk); sel = 1'b1;
    run_op("m0 rpc4", 1'b0, GEN_HDR, 32'h0, 32'h0, GEN_TGT,
           mk_exp(56, 1'b1, 1'b1, 32'h7c2bac1d, GEN_DIG), -1);
    @(negedge clk); sel = 1'b0;

    run_op("sweep hit", 1'b1, GEN_HDR, 32'h7c2bac1b, 32'd4, GEN_TGT,
           mk_exp(466, 1'b1, 1'b1, 32'h7c2bac1d, GEN_DIG), -1);

    run_op("sweep empty", 1'b1, GEN_HDR, 32'h12345678, 32'd0, {256{1'b1}},
           mk_exp(2, 1'b0, 1'b1, 32'h7c2bac1d, GEN_DIG), -1);

    run_op("sweep wrap", 1'b1, GEN_HDR, 32'hFFFFFFFF, 32'd2, 256'h0,
           mk_exp(333, 1'b0, 1'b0, 32'h00000000, 256'h0), -1);

    // Abort a run with an asynchronous reset in cycle 100
    @(negedge clk);
    mode_v = 1'b0; hdr_v = GEN_HDR; tgt_v = GEN_TGT; start_v = 1'b1;
    @(posedge clk); #1;
    start_v = 1'b0;
    repeat (99) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst busy",  256'(bus1.busy),      256'(0));
    check("arst done",  256'(bus1.done),      256'(0));
    check("arst dig",   bus1.digest,          256'(0));
    check("arst found", 256'(bus1.found),     256'(0));
    check("arst nonce", 256'(bus1.nonce_out), 256'(0));
    @(negedge clk); reset = 1'b0;

    run_op("after arst", 1'b0, GEN_HDR, 32'h0, 32'h0, GEN_TGT,
           mk_exp(200, 1'b1, 1'b1, 32'h7c2bac1d, GEN_DIG), -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
